// File: rtl/spi_write_sequencer.sv
// Queued SPI register-write sequencer. A small FIFO buffers {addr, data}
// requests; the FSM sends each one as a 16-bit mode-0 write frame,
// MSB first. The first frame bit is the write flag.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no frame; waits for a queued entry
// SETUP | ncs low, copi = frame bit 15, sclk low for CLK_DIV cycles
// SHIFT | 16 bits, each sclk high CLK_DIV then low CLK_DIV cycles
// HOLD  | sclk low, ncs still low for CLK_DIV cycles
// GAP   | ncs high for 2*CLK_DIV cycles before the next frame
module spi_write_sequencer #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       sclk,
  output logic       ncs,
  output logic       copi,
  output logic       busy,
  output logic       frame_done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  // Timer holds (cycles - 1); terminal count is zero.
  localparam logic [8:0] HALF_LD = 9'(CLK_DIV - 1);
  localparam logic [8:0] GAP_LD  = 9'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t        state, state_nxt;
  logic [14:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          push, pop, fifo_empty, timer_tc;

  logic [8:0]  timer, timer_nxt;
  logic [3:0]  bit_cnt, bit_cnt_nxt;
  logic [14:0] shreg, shreg_nxt;
  logic        sclk_nxt, ncs_nxt, copi_nxt, frame_done_nxt;

  assign req_ready  = (count != DEPTH_C);
  assign fifo_empty = (count == '0);
  assign push       = req_valid && req_ready;
  assign timer_tc   = (timer == '0);
  assign busy       = (state != IDLE) || !fifo_empty;
  // The head is consumed exactly when a frame starts.
  assign pop        = (state_nxt == SETUP) && (state != SETUP);

  // FIFO storage; no reset needed, validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {req_addr, req_data};
  end

  // FIFO pointers and occupancy; simultaneous push and pop cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = SETUP;
      SETUP:   if (timer_tc) state_nxt = SHIFT;
      SHIFT:   if (timer_tc && !sclk && bit_cnt == 4'd15) state_nxt = HOLD;
      HOLD:    if (timer_tc) state_nxt = GAP;
      GAP:     if (timer_tc) state_nxt = fifo_empty ? IDLE : SETUP;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs, timer and shifter.
  always_comb begin
    sclk_nxt       = sclk;
    ncs_nxt        = ncs;
    copi_nxt       = copi;
    frame_done_nxt = 1'b0;
    shreg_nxt      = shreg;
    bit_cnt_nxt    = bit_cnt;
    timer_nxt      = timer_tc ? timer : timer - 9'd1;
    case (state)
      SETUP: begin
        if (timer_tc) begin
          sclk_nxt  = 1'b1;
          timer_nxt = HALF_LD;
        end
      end
      SHIFT: begin
        if (timer_tc) begin
          timer_nxt = HALF_LD;
          if (sclk) begin
            // Falling sclk is the only point where copi advances.
            sclk_nxt  = 1'b0;
            copi_nxt  = shreg[14];
            shreg_nxt = {shreg[13:0], 1'b0};
          end else if (bit_cnt != 4'd15) begin
            sclk_nxt    = 1'b1;
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
        end
      end
      HOLD: begin
        if (timer_tc) begin
          ncs_nxt        = 1'b1;
          copi_nxt       = 1'b0;
          frame_done_nxt = 1'b1;
          timer_nxt      = GAP_LD;
        end
      end
      default: ;
    endcase
    if (pop) begin
      // Bit 15 (write flag) goes straight to copi; shreg keeps bits 14:0.
      shreg_nxt   = mem[rptr];
      copi_nxt    = 1'b1;
      ncs_nxt     = 1'b0;
      sclk_nxt    = 1'b0;
      bit_cnt_nxt = '0;
      timer_nxt   = HALF_LD;
    end
  end

  // Output, timer and shifter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk       <= 1'b0;
      ncs        <= 1'b1;
      copi       <= 1'b0;
      frame_done <= 1'b0;
      timer      <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
    end else begin
      sclk       <= sclk_nxt;
      ncs        <= ncs_nxt;
      copi       <= copi_nxt;
      frame_done <= frame_done_nxt;
      timer      <= timer_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shreg      <= shreg_nxt;
    end
  end

endmodule

// File: tb/tb_spi_write_sequencer.sv
// Bench for spi_write_sequencer: one instance at CLK_DIV=4 for function,
// one at CLK_DIV=255 for long timing. A per-instance line monitor rebuilds
// frames from sclk/copi and compares them with a scoreboard queue.
module tb_spi_write_sequencer;

  localparam int DIV_A = 4;
  localparam int DIV_B = 255;
  localparam int DEPTH = 4;
  localparam int NV    = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       valid_a, ready_a, sclk_a, ncs_a, copi_a, busy_a, fd_a;
  logic [6:0] addr_a;
  logic [7:0] data_a;
  logic       valid_b, ready_b, sclk_b, ncs_b, copi_b, busy_b, fd_b;
  logic [6:0] addr_b;
  logic [7:0] data_b;

  spi_write_sequencer #(.CLK_DIV(DIV_A), .FIFO_DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(valid_a), .req_ready(ready_a),
    .req_addr(addr_a), .req_data(data_a), .sclk(sclk_a), .ncs(ncs_a),
    .copi(copi_a), .busy(busy_a), .frame_done(fd_a)
  );

  spi_write_sequencer #(.CLK_DIV(DIV_B), .FIFO_DEPTH(DEPTH)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(valid_b), .req_ready(ready_b),
    .req_addr(addr_b), .req_data(data_b), .sclk(sclk_b), .ncs(ncs_b),
    .copi(copi_b), .busy(busy_b), .frame_done(fd_b)
  );

  typedef struct {
    logic [6:0]  addr;
    logic [7:0]  data;
    logic [15:0] frame;
  } vec_t;

  typedef struct {
    logic        p_sclk, p_ncs, p_copi, p_fd;
    bit          in_frame, seen_end;
    int          low_cnt, high_run, low_run, gap_cnt, rises;
    logic [15:0] shv;
    int          fd_total, frames_started;
    int          bad_copi, bad_fd, bad_run;
  } mon_t;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] sb_a[$];
  logic [15:0] sb_b[$];
  mon_t        mon_a, mon_b;
  vec_t        vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One sample of the SPI lines, taken 1 time unit after each rising clk.
  task automatic mon_step(input string tag, input int div, input logic sclk,
                          input logic ncs, input logic copi, input logic fd,
                          input logic rst, inout mon_t m,
                          output bit done, output logic [15:0] word);
    done = 1'b0;
    word = m.shv;
    if (!rst) begin
      m.in_frame = 1'b0;
      m.seen_end = 1'b0;
      m.p_sclk   = 1'b0;
      m.p_ncs    = 1'b1;
      m.p_copi   = 1'b0;
      m.p_fd     = 1'b0;
      m.rises    = 0;
      return;
    end
    if (fd) m.fd_total++;
    if (fd && m.p_fd) m.bad_fd++;
    if (ncs && copi) m.bad_copi++;
    if (ncs) begin
      if (!m.p_ncs) begin
        done = 1'b1;
        word = m.shv;
        check({tag, "_rises"}, m.rises, 16);
        check({tag, "_ncs_low_cycles"}, m.low_cnt, 34 * div);
        check({tag, "_frame_done_at_ncs_rise"}, fd, 1'b1);
        m.in_frame = 1'b0;
        m.seen_end = 1'b1;
        m.gap_cnt  = 0;
      end
      if (sclk) m.bad_run++;
      m.gap_cnt++;
    end else begin
      if (m.p_ncs) begin
        if (m.seen_end) check({tag, "_gap_ok"}, m.gap_cnt >= 2 * div, 1'b1);
        m.in_frame = 1'b1;
        m.low_cnt  = 0;
        m.rises    = 0;
        m.shv      = '0;
        m.low_run  = 0;
        m.high_run = 0;
        m.frames_started++;
      end else if (copi != m.p_copi && !(m.p_sclk && !sclk)) begin
        m.bad_copi++;
      end
      m.low_cnt++;
      if (sclk && !m.p_sclk) begin
        m.rises++;
        m.shv = {m.shv[14:0], copi};
        if (m.low_run != div) m.bad_run++;
        m.high_run = 0;
      end
      if (!sclk && m.p_sclk) begin
        if (m.high_run != div) m.bad_run++;
        m.low_run = 0;
      end
      if (sclk) m.high_run++;
      else      m.low_run++;
    end
    m.p_sclk = sclk;
    m.p_ncs  = ncs;
    m.p_copi = copi;
    m.p_fd   = fd;
  endtask

  always @(posedge clk) begin : mon_a_proc
    bit          done;
    logic [15:0] w;
    #1;
    mon_step("a", DIV_A, sclk_a, ncs_a, copi_a, fd_a, rst_n, mon_a, done, w);
    if (done) begin
      check("a_frame_expected", sb_a.size() != 0, 1'b1);
      if (sb_a.size() != 0) check("a_frame", w, sb_a.pop_front());
    end
  end

  always @(posedge clk) begin : mon_b_proc
    bit          done;
    logic [15:0] w;
    #1;
    mon_step("b", DIV_B, sclk_b, ncs_b, copi_b, fd_b, rst_n, mon_b, done, w);
    if (done) begin
      check("b_frame_expected", sb_b.size() != 0, 1'b1);
      if (sb_b.size() != 0) check("b_frame", w, sb_b.pop_front());
    end
  end

  // Call at a falling clk edge; presents one request for one rising edge.
  task automatic send_a(input logic [6:0] a, input logic [7:0] d,
                        input logic [15:0] exp, output bit acc);
    valid_a = 1'b1;
    addr_a  = a;
    data_a  = d;
    acc     = ready_a;
    if (acc) sb_a.push_back(exp);
    @(negedge clk);
    valid_a = 1'b0;
  endtask

  task automatic wait_idle_a(input int max, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(posedge clk);
      #2;
      if (!busy_a) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1'b1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  bit          acc, acc2, ok;
  logic [5:0]  acc_bits;
  logic [6:0]  fa;
  logic [7:0]  fdat;
  int          fd0, fd_acc, starts1;

  initial begin
    vecs[0] = '{addr: 7'h04, data: 8'h80, frame: 16'h8480};
    vecs[1] = '{addr: 7'h7F, data: 8'hFF, frame: 16'hFFFF};
    vecs[2] = '{addr: 7'h00, data: 8'h00, frame: 16'h8000};
    vecs[3] = '{addr: 7'h55, data: 8'hAA, frame: 16'hD5AA};
    vecs[4] = '{addr: 7'h2A, data: 8'h55, frame: 16'hAA55};
    vecs[5] = '{addr: 7'h12, data: 8'h34, frame: 16'h9234};
    vecs[6] = '{addr: 7'h01, data: 8'h01, frame: 16'h8101};
    vecs[7] = '{addr: 7'h40, data: 8'h0F, frame: 16'hC00F};

    valid_a = 1'b0; addr_a = '0; data_a = '0;
    valid_b = 1'b0; addr_b = '0; data_b = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs_a", {sclk_a, ncs_a, copi_a, fd_a, busy_a, ready_a}, 6'b010001);
    check("reset_outputs_b", {sclk_b, ncs_b, copi_b, fd_b, busy_b, ready_b}, 6'b010001);

    // Release and push on the very first edge; ncs must fall one edge later.
    rst_n = 1'b1;
    send_a(7'h04, 8'h80, 16'h8480, acc);
    check("first_push_accepted", acc, 1'b1);
    check("ncs_high_after_push_edge", ncs_a, 1'b1);
    check("busy_after_push", busy_a, 1'b1);
    @(negedge clk);
    check("ncs_low_next_edge", ncs_a, 1'b0);
    check("copi_write_bit", copi_a, 1'b1);
    wait_idle_a(400, "single_idle");
    check("single_frame_done_count", mon_a.fd_total, 1);

    for (int i = 0; i < NV; i++) begin
      fd0 = mon_a.fd_total;
      @(negedge clk);
      send_a(vecs[i].addr, vecs[i].data, vecs[i].frame, acc);
      check("vec_accept", acc, 1'b1);
      wait_idle_a(400, "vec_idle");
      check("vec_frame_done", mon_a.fd_total - fd0, 1);
    end

    // Push landing on the IDLE->SETUP pop edge.
    @(negedge clk);
    send_a(7'h21, 8'h3C, {1'b1, 7'h21, 8'h3C}, acc);
    send_a(7'h22, 8'hC3, {1'b1, 7'h22, 8'hC3}, acc2);
    check("pushpop_accept", {acc, acc2}, 2'b11);
    check("pushpop_count", 32'(dut_a.count), 1);
    check("pushpop_ncs_low", ncs_a, 1'b0);
    wait_idle_a(800, "pushpop_idle");

    // Six back-to-back pushes into an idle, empty sequencer.
    fd0 = mon_a.fd_total;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      fa   = 7'(16 + i);
      fdat = 8'(160 + i);
      send_a(fa, fdat, {1'b1, fa, fdat}, acc);
      acc_bits[i] = acc;
    end
    check("fill_accept_pattern", acc_bits, 6'b011111);
    ok = 1'b0;
    fd_acc = fd0;
    if (!acc_bits[5]) begin
      valid_a = 1'b1;
      addr_a  = 7'h15;
      data_a  = 8'hA5;
      for (int k = 0; k < 2000; k++) begin
        if (ready_a) begin
          fd_acc = mon_a.fd_total;
          sb_a.push_back({1'b1, 7'h15, 8'hA5});
          @(negedge clk);
          ok = 1'b1;
          break;
        end
        @(negedge clk);
      end
      valid_a = 1'b0;
    end
    check("fill_sixth_accepted", ok, 1'b1);
    check("fill_ready_low_until_first_done", fd_acc - fd0, 1);
    wait_idle_a(3000, "fill_idle");
    check("fill_frame_done_count", mon_a.fd_total - fd0, 6);

    // Reset in the middle of a frame with two entries still queued.
    @(negedge clk);
    send_a(7'h30, 8'h01, {1'b1, 7'h30, 8'h01}, acc);
    send_a(7'h31, 8'h02, {1'b1, 7'h31, 8'h02}, acc);
    send_a(7'h32, 8'h03, {1'b1, 7'h32, 8'h03}, acc);
    ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(posedge clk);
      #2;
      if (mon_a.in_frame && mon_a.rises == 7) begin
        ok = 1'b1;
        break;
      end
    end
    check("rst_reached_7th_rise", ok, 1'b1);
    check("rst_queue_depth", 32'(dut_a.count), 2);
    fd0 = mon_a.fd_total;
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", {sclk_a, ncs_a, copi_a, fd_a, busy_a, ready_a}, 6'b010001);
    check("rst_mid_count", 32'(dut_a.count), 0);
    sb_a.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    starts1 = mon_a.frames_started;
    repeat (400) @(negedge clk);
    check("rst_no_new_frames", mon_a.frames_started - starts1, 0);
    check("rst_no_frame_done", mon_a.fd_total - fd0, 0);
    check("rst_idle_after", {busy_a, ncs_a}, 2'b01);

    // Slowest divider: one frame.
    @(negedge clk);
    valid_b = 1'b1;
    addr_b  = 7'h3C;
    data_b  = 8'h5A;
    check("b_ready", ready_b, 1'b1);
    sb_b.push_back(16'hBC5A);
    @(negedge clk);
    valid_b = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 10000; k++) begin
      @(posedge clk);
      #2;
      if (!busy_b) begin
        ok = 1'b1;
        break;
      end
    end
    check("b_idle", ok, 1'b1);
    check("b_frame_done_count", mon_b.fd_total, 1);

    repeat (5) @(negedge clk);
    check("a_scoreboard_empty", sb_a.size(), 0);
    check("b_scoreboard_empty", sb_b.size(), 0);
    check("a_copi_rule_violations", mon_a.bad_copi, 0);
    check("a_frame_done_width_violations", mon_a.bad_fd, 0);
    check("a_sclk_timing_violations", mon_a.bad_run, 0);
    check("b_copi_rule_violations", mon_b.bad_copi, 0);
    check("b_frame_done_width_violations", mon_b.bad_fd, 0);
    check("b_sclk_timing_violations", mon_b.bad_run, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_write_sequencer.md
SPI_WRITE_SEQUENCER -- requirements
Module: spi_write_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk  input  1  system clock; rst_n  input  1  asynchronous active-low reset.
REQ-002 The block SHALL have parameter CLK_DIV, default 4, giving the clk cycles per sclk half-period; legal values are 4..255.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, giving the request FIFO entries; legal values are powers of 2, 2..16.
REQ-004 The block SHALL have port req_valid  input  1  requester presents a write.
REQ-005 The block SHALL have port req_ready  output  1  FIFO can accept a write this cycle.
REQ-006 The block SHALL have port req_addr  input  7  target register address.
REQ-007 The block SHALL have port req_data  input  8  register write data.
REQ-008 The block SHALL have port sclk  output  1  SPI clock, idle low (mode 0).
REQ-009 The block SHALL have port ncs  output  1  SPI chip select, active low.
REQ-010 The block SHALL have port copi  output  1  serial data, MSB first.
REQ-011 The block SHALL have port busy  output  1  FIFO non-empty or frame in progress.
REQ-012 The block SHALL have port frame_done  output  1  one-cycle pulse per completed frame.

Function
REQ-013 FIFO push SHALL occur only on req_valid && req_ready, storing {req_addr, req_data}.
REQ-014 req_ready SHALL be 1 exactly when the registered FIFO count is below FIFO_DEPTH.
REQ-015 A push and a pop in the same cycle SHALL leave the count unchanged, with no entry lost or duplicated.
REQ-016 Read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-017 Each frame SHALL be 16 bits: bit15 = 1 (write), bits14:8 = addr, bits7:0 = data, shifted MSB first.
REQ-018 The FSM SHALL have states IDLE, SETUP, SHIFT, HOLD, GAP; all outputs SHALL be registered.
REQ-019 IDLE -> SETUP when FIFO is non-empty: pop the head into the shift register, drive ncs low and copi = frame bit15 on the same clk edge.
REQ-020 SETUP SHALL last CLK_DIV cycles with sclk low, then move to SHIFT.
REQ-021 SHIFT, per bit: sclk high for CLK_DIV cycles, then low for CLK_DIV cycles; copi SHALL update to the next bit only on the high->low sclk transition.
REQ-022 SHIFT SHALL produce exactly 16 rising sclk edges, then enter HOLD with sclk low.
REQ-023 HOLD SHALL last CLK_DIV cycles with ncs low, then drive ncs high, pulse frame_done for 1 cycle, and enter GAP.
REQ-024 GAP SHALL hold ncs high for 2*CLK_DIV cycles, then go to IDLE (or directly to SETUP if the FIFO is non-empty).
REQ-025 ncs low time per frame SHALL be CLK_DIV*(2+32) cycles.
REQ-026 Latency: a push into an empty FIFO with FSM in IDLE at edge N SHALL give ncs low at edge N+1.
REQ-027 Pushes during any state SHALL be accepted when not full; frames SHALL never be truncated or merged.
REQ-028 busy SHALL equal (state != IDLE) || (count != 0).
REQ-029 copi SHALL be 0 whenever ncs is high.

Reset
REQ-030 While rst_n is low, the block SHALL asynchronously force: sclk=0, ncs=1, copi=0, frame_done=0, busy=0, req_ready=1, FIFO count and pointers = 0, state = IDLE.
REQ-031 Reset mid-frame SHALL abort the frame immediately (ncs high without a frame_done pulse) and discard all queued entries.
REQ-032 The first push SHALL be accepted on the first clk edge after rst_n deasserts.

Verification
REQ-033 Single write (CLK_DIV=4): addr 0x04, data 0x80 -> copi sampled at the 16 sclk rises = 0x8480; ncs low 136 cycles; one frame_done.
REQ-034 Fill (FIFO_DEPTH=4): 6 back-to-back pushes while the FSM is in IDLE -> 5 accepted, req_ready low until the first frame_done, 6th accepted next cycle; 6 frames in push order with ncs high >= 8 cycles between them.
REQ-035 Simultaneous push/pop: push in the cycle of IDLE->SETUP with count 1 -> count stays 1; the next frame carries the pushed data.
REQ-036 Reset mid-frame: assert rst_n after the 7th sclk rise with 2 entries queued -> ncs=1 and sclk=0 immediately; no frame_done; busy=0; no frames after release.
REQ-037 Edge values: addr 0x7F, data 0xFF -> frame 0xFFFF; addr 0x00, data 0x00 -> frame 0x8000.
REQ-038 CLK_DIV=255: one frame -> ncs low 8670 cycles; sclk high/low exactly 255 cycles each.
